arbitro_desplazador: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit barrel shifter. The CPU execute stage (requester 0) and the DMA/protocol unit (requester 1) each issue shift operations through a request/grant handshake. The block latches the winner's operands, drives the shifter's control and data inputs from registers, captures the combinational shifter result one cycle later, and returns it with a one-cycle valid strobe to the owner. It sits between the ALU/DMA front ends and the shifter instance in the datapath.

---
 rtl/arbitro_desplazador.sv | 144 ++++++++++++++
 tb/tb_arbitro_desplazador.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_desplazador.sv
// Two-requester arbiter/sequencer for the shared barrel shifter.
// Latches winner operands, captures shifter result, strobes owner.
//
// Ports:
//   clk, reset        clock, sync active-low reset
//   req0/1            shift request (0 = CPU, 1 = DMA)
//   dato0/1           operand to shift
//   shamt0/1          shift amount
//   dir0/1            1 = logical right, 0 = logical left
//   gnt0/1            one-cycle grant pulse
//   valido0/1         one-cycle result strobe
//   resultado         registered result
//   ocupado           operation in flight
//   sh_dato/shamt/dir registered shifter controls
//   sh_res            combinational shifter output
module arbitro_desplazador #(
  parameter int ANCHO   = 32,
  parameter int MODO_RR = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [ANCHO-1:0] dato0,
  input  logic [ANCHO-1:0] dato1,
  input  logic [4:0]       shamt0,
  input  logic [4:0]       shamt1,
  input  logic             dir0,
  input  logic             dir1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             valido0,
  output logic             valido1,
  output logic [ANCHO-1:0] resultado,
  output logic             ocupado,
  output logic [ANCHO-1:0] sh_dato,
  output logic [4:0]       sh_shamt,
  output logic             sh_dir,
  input  logic [ANCHO-1:0] sh_res
);

  typedef enum logic {
    IDLE = 1'b0,
    EJEC = 1'b1
  } estado_t;

  estado_t          est_q, est_d;
  logic             ptr_q, ptr_d;
  logic             own_q, own_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             val0_q, val0_d;
  logic             val1_q, val1_d;
  logic [ANCHO-1:0] res_q, res_d;
  logic [ANCHO-1:0] dat_q, dat_d;
  logic [4:0]       sha_q, sha_d;
  logic             dir_q, dir_d;
  logic             win;

  // ptr holds the last-served requester; on a tie
  // round-robin picks the other one.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      if (MODO_RR != 0) win = ~ptr_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  always_comb begin
    est_d  = est_q;
    ptr_d  = ptr_q;
    own_d  = own_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    val0_d = 1'b0;
    val1_d = 1'b0;
    res_d  = res_q;
    dat_d  = dat_q;
    sha_d  = sha_q;
    dir_d  = dir_q;
    unique case (est_q)
      IDLE: begin
        if (req0 || req1) begin
          dat_d  = win ? dato1 : dato0;
          sha_d  = win ? shamt1 : shamt0;
          dir_d  = win ? dir1 : dir0;
          gnt0_d = ~win;
          gnt1_d = win;
          own_d  = win;
          ptr_d  = win;
          est_d  = EJEC;
        end
      end
      EJEC: begin
        res_d  = sh_res;
        val0_d = ~own_q;
        val1_d = own_q;
        est_d  = IDLE;
      end
      default: est_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      est_q  <= IDLE;
      ptr_q  <= 1'b1;
      own_q  <= 1'b0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      val0_q <= 1'b0;
      val1_q <= 1'b0;
      res_q  <= '0;
      dat_q  <= '0;
      sha_q  <= '0;
      dir_q  <= 1'b0;
    end else begin
      est_q  <= est_d;
      ptr_q  <= ptr_d;
      own_q  <= own_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      val0_q <= val0_d;
      val1_q <= val1_d;
      res_q  <= res_d;
      dat_q  <= dat_d;
      sha_q  <= sha_d;
      dir_q  <= dir_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign valido0   = val0_q;
  assign valido1   = val1_q;
  assign resultado = res_q;
  assign ocupado   = (est_q == EJEC);
  assign sh_dato   = dat_q;
  assign sh_shamt  = sha_q;
  assign sh_dir    = dir_q;

endmodule

// File: tb/tb_arbitro_desplazador.sv
// Directed bench for arbitro_desplazador.
// Round-robin (a) and fixed-priority (b) instances share stimulus.
module tb_arbitro_desplazador;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] dato0, dato1;
  logic [4:0]  shamt0, shamt1;
  logic        dir0, dir1;

  logic        g0a, g1a, v0a, v1a, oca, sda;
  logic [31:0] resa, sdata, shra;
  logic [4:0]  ssha;
  logic        g0b, g1b, v0b, v1b, ocb, sdb;
  logic [31:0] resb, sdatb, shrb;
  logic [4:0]  sshb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign shra = sda ? (sdata >> ssha) : (sdata << ssha);
  assign shrb = sdb ? (sdatb >> sshb) : (sdatb << sshb);

  arbitro_desplazador #(.ANCHO(32), .MODO_RR(1)) u_a (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .dato0(dato0), .dato1(dato1),
    .shamt0(shamt0), .shamt1(shamt1),
    .dir0(dir0), .dir1(dir1),
    .gnt0(g0a), .gnt1(g1a),
    .valido0(v0a), .valido1(v1a),
    .resultado(resa), .ocupado(oca),
    .sh_dato(sdata), .sh_shamt(ssha),
    .sh_dir(sda), .sh_res(shra)
  );

  arbitro_desplazador #(.ANCHO(32), .MODO_RR(0)) u_b (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .dato0(dato0), .dato1(dato1),
    .shamt0(shamt0), .shamt1(shamt1),
    .dir0(dir0), .dir1(dir1),
    .gnt0(g0b), .gnt1(g1b),
    .valido0(v0b), .valido1(v1b),
    .resultado(resb), .ocupado(ocb),
    .sh_dato(sdatb), .sh_shamt(sshb),
    .sh_dir(sdb), .sh_res(shrb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] fa();
    return {g0a, g1a, v0a, v1a};
  endfunction

  function automatic logic [3:0] fb();
    return {g0b, g1b, v0b, v1b};
  endfunction

  logic [3:0]  ea [1:8];
  logic [3:0]  eb [1:8];
  logic [31:0] ra [1:8];
  logic [31:0] rb [1:8];

  initial begin
    ea[1] = 4'b1000; ea[2] = 4'b0010;
    ea[3] = 4'b0100; ea[4] = 4'b0001;
    ea[5] = 4'b1000; ea[6] = 4'b0010;
    ea[7] = 4'b0100; ea[8] = 4'b0001;
    for (int i = 1; i <= 8; i++)
      eb[i] = (i % 2 == 1) ? 4'b1000 : 4'b0010;
    ra[2] = 32'h2345_6780; ra[4] = 32'h7800_0007;
    ra[6] = 32'h2345_6780; ra[8] = 32'h7800_0007;
    for (int i = 2; i <= 8; i += 2)
      rb[i] = 32'h2345_6780;

    reset  = 1'b0;
    req0   = 1'b1;
    req1   = 1'b0;
    dato0  = 32'h8000_0000;
    shamt0 = 5'd4;
    dir0   = 1'b1;
    dato1  = 32'h0;
    shamt1 = 5'd0;
    dir1   = 1'b0;

    // reset held with req0 high
    tick();
    tick();
    chk("rst_flags", {28'd0, fa()}, 32'd0);
    chk("rst_ocup", {31'd0, oca}, 32'd0);
    chk("rst_res", resa, 32'd0);
    chk("rst_shd", sdata, 32'd0);
    chk("rst_shs", {27'd0, ssha}, 32'd0);
    chk("rst_dir", {31'd0, sda}, 32'd0);

    // CPU right shift
    reset = 1'b1;
    tick();
    chk("cpu_gnt", {28'd0, fa()}, 32'h8);
    chk("cpu_ocup", {31'd0, oca}, 32'd1);
    chk("cpu_shd", sdata, 32'h8000_0000);
    chk("cpu_shs", {27'd0, ssha}, 32'd4);
    chk("cpu_dir", {31'd0, sda}, 32'd1);
    req0 = 1'b0;
    tick();
    chk("cpu_val", {28'd0, fa()}, 32'h2);
    chk("cpu_ocup2", {31'd0, oca}, 32'd0);
    chk("cpu_res", resa, 32'h0800_0000);
    tick();
    chk("cpu_idle", {28'd0, fa()}, 32'd0);
    chk("cpu_hold", resa, 32'h0800_0000);

    // DMA left shift, then shamt 0
    req1   = 1'b1;
    dato1  = 32'h0000_00FF;
    shamt1 = 5'd8;
    dir1   = 1'b0;
    tick();
    chk("dma_gnt", {28'd0, fb()}, 32'h4);
    req1 = 1'b0;
    tick();
    chk("dma_val", {28'd0, fb()}, 32'h1);
    chk("dma_res", resb, 32'h0000_FF00);
    req1   = 1'b1;
    shamt1 = 5'd0;
    tick();
    chk("dma0_gnt", {28'd0, fa()}, 32'h4);
    req1 = 1'b0;
    tick();
    chk("dma0_val", {28'd0, fa()}, 32'h1);
    chk("dma0_res", resa, 32'h0000_00FF);

    // tie after fresh reset
    reset = 1'b0;
    tick();
    reset  = 1'b1;
    req0   = 1'b1;
    req1   = 1'b1;
    dato0  = 32'h1234_5678;
    shamt0 = 5'd4;
    dir0   = 1'b0;
    dato1  = 32'hF000_000F;
    shamt1 = 5'd1;
    dir1   = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("rr_e%0d", i), {28'd0, fa()}, {28'd0, ea[i]});
      chk($sformatf("fx_e%0d", i), {28'd0, fb()}, {28'd0, eb[i]});
      if (i % 2 == 0) begin
        chk($sformatf("rr_r%0d", i), resa, ra[i]);
        chk($sformatf("fx_r%0d", i), resb, rb[i]);
      end
    end

    // fixed priority: DMA only once CPU drops
    req0 = 1'b0;
    tick();
    chk("fx_dma_gnt", {28'd0, fb()}, 32'h4);
    req1 = 1'b0;
    tick();
    chk("fx_dma_val", {28'd0, fb()}, 32'h1);
    chk("fx_dma_res", resb, 32'h7800_0007);

    // reset during EJEC
    req0 = 1'b1;
    tick();
    chk("ab_gnt", {28'd0, fa()}, 32'h8);
    req0  = 1'b0;
    reset = 1'b0;
    tick();
    chk("ab_flags", {28'd0, fa()}, 32'd0);
    chk("ab_ocup", {31'd0, oca}, 32'd0);
    chk("ab_res", resa, 32'd0);
    chk("ab_shd", sdata, 32'd0);
    reset = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    tick();
    chk("ab_ptr", {28'd0, fa()}, 32'h8);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("ab_val", {28'd0, fa()}, 32'h2);
    chk("ab_res2", resa, 32'h2345_6780);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
